regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-back scheduler for the 16 x 16-bit register file. It shares the file's two write ports among three result producers: the single-cycle ALU, the load unit, and the multi-cycle multiply/divide unit (MDU).
- Main port: wr/wrAddr/wrData.
- Special port: wrR15/wrDataR15, which always targets register 0.

It also keeps a per-register pending scoreboard so decode can stall on read-after-write hazards. It sits between the execute units and the register file.

## Interface
Parameters:
- ADDR_W, 4, register address width
- DATA_W, 16, data width
- NREG, 16, register count (1<<ADDR_W)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid / alu_ready  in / out  1  ALU write-back handshake
- alu_addr / alu_data  in  ADDR_W / DATA_W  ALU destination and result
- ld_valid / ld_ready  in / out  1  load write-back handshake
- ld_addr / ld_data  in  ADDR_W / DATA_W  load destination and data
- md_valid / md_ready  in / out  1  MDU write-back handshake
- md_addr, md_lo, md_hi  in  ADDR_W, DATA_W, DATA_W  MDU destination, low result, high result (high result goes to R0)
- wr, wrAddr, wrData  out  1, ADDR_W, DATA_W  register-file main write port
- wrR15, wrDataR15  out  1, DATA_W  register-file R0 write port
- rsv_valid, rsv_addr, rsv_r0  in  1, ADDR_W, 1  decode reservation of a destination register, optionally also R0
- chk_addr_a, chk_addr_b  in  ADDR_W  decode source registers
- hazard  out  1  combinational: pending[chk_addr_a] | pending[chk_addr_b]
- pending  out  NREG  scoreboard bits

## Operation
Arbitration:
- Round-robin arbitration among ALU(0), LD(1), MDU(2).
- Grant goes to the first valid requester after the last granted index.
- After reset the last-granted index is 2, so the priority order is ALU > LD > MDU.
- At most one grant per cycle.

Handshake:
- ready_i is combinational: ready_i = grant_i. It depends only on the valid inputs and the round-robin pointer.
- Transfer occurs when valid & ready.
- A requester holds valid, addr and data stable until it is accepted.
- The pointer updates only on a transfer.

Output register:
- Accepted request drives wr=1, wrAddr=addr, wrData=data in the next cycle. For the MDU, wrData=md_lo.
- An MDU transfer with md_addr != 0 also drives wrR15=1, wrDataR15=md_hi.
- An MDU transfer with md_addr == 0 drives only the main port, with md_lo; md_hi is discarded. This matches the file's rule that the main port wins on R0.
- No transfer means wr=0 and wrR15=0 next cycle; the data outputs hold their previous values.

Scoreboard:
- rsv_valid sets pending[rsv_addr] on the next edge; rsv_r0 additionally sets pending[0].
- A bit clears on the edge where the output register presents a write to it, i.e. the edge that updates the register file:
  - wr clears pending[wrAddr].
  - wrR15 clears pending[0].
- If the same bit is set and cleared on one edge, the set wins; the new reservation survives.
- Writing a register that is not pending is legal and leaves the bit at 0.

Reset:
- rst=1 clears all pending bits and sets wr=0, wrR15=0, wrAddr=0, wrData=0, wrDataR15=0.
- The round-robin pointer returns to 2.
- All ready outputs read 0 while rst=1.
- An accepted but unissued write is dropped. Requesters must re-present it after reset.

## Timing
- Latency: transfer at edge N gives wr/wrR15 high during cycle N+1, and the register file is written at edge N+1.
- pending stays high through cycle N+1, so hazard covers the in-flight write. Decode may read the register from cycle N+2.
- Throughput: one write-back per cycle.
- hazard and the ready outputs are purely combinational from the current inputs and state. They have no registered delay.
- MDU writes to both ports in the same cycle are never split across cycles.

## Structure
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W, NREG
  - R0_IDX=0
  - requester index constants REQ_ALU=0, REQ_LD=1, REQ_MDU=2
- One sub-module: rr_arb3, a 3-way round-robin arbiter with a registered pointer. Its interface is req[2:0], a transfer-taken strobe, and a one-hot gnt[2:0].
- Scoreboard, output register and MDU port-split logic live in regfile_wb_sched.

## Test plan
- **Reset:** hold rst=1 while driving all valids -> all ready=0, wr=0, wrR15=0, pending=0. After release, first grant goes to ALU.
- **Round-robin fairness:** ALU, LD and MDU all valid continuously -> grants cycle ALU, LD, MDU, ALU..., and wr is high every cycle.
- **MDU split:** md_addr=5, md_lo=16'h1234, md_hi=16'hABCD -> next cycle wr=1, wrAddr=5, wrData=16'h1234, wrR15=1, wrDataR15=16'hABCD.
- **MDU to R0:** md_addr=0, md_lo=16'h0050 -> next cycle wr=1, wrAddr=0, wrData=16'h0050, wrR15=0.
- **Scoreboard and hazard:**
  - rsv_valid with rsv_addr=3, then chk_addr_a=3 -> hazard=1.
  - ALU write to 3 accepted at edge N -> hazard stays 1 in cycle N+1 and is 0 in cycle N+2.
  - rsv for 3 at edge N+1 -> pending[3] stays 1 (set wins).
- **Reset mid-operation:** accept an LD write, assert rst in the next cycle -> wr=0 and the write never reaches the register file; pending=0.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared widths, register indices and requester indices for the register-file
// write-back scheduler.
package regfile_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] R0_IDX = '0;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LD  = 2'd1,
    REQ_MDU = 2'd2
  } req_idx_e;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// Bundle of the producer handshakes, register-file write ports and decode
// scoreboard signals. A transfer happens on a rising edge where valid & ready.
interface regfile_wb_sched_if;
  import regfile_pkg::*;

  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid, ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              md_valid, md_ready;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_lo, md_hi;

  logic              wr;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrR15;
  logic [DATA_W-1:0] wrDataR15;

  logic              rsv_valid, rsv_r0;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] chk_addr_a, chk_addr_b;
  logic              hazard;
  logic [NREG-1:0]   pending;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    output md_valid, md_addr, md_lo, md_hi,
    output rsv_valid, rsv_addr, rsv_r0, chk_addr_a, chk_addr_b,
    input  alu_ready, ld_ready, md_ready,
    input  wr, wrAddr, wrData, wrR15, wrDataR15, hazard, pending
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    input  md_valid, md_addr, md_lo, md_hi,
    input  rsv_valid, rsv_addr, rsv_r0, chk_addr_a, chk_addr_b,
    output alu_ready, ld_ready, md_ready,
    output wr, wrAddr, wrData, wrR15, wrDataR15, hazard, pending
  );
endinterface

// File: rtl/regfile_wb_sched_rr_arb3.sv
// 3-way round-robin arbiter: grants the first requester after the last granted
// index; the pointer moves only when the grant is taken.
module rr_arb3
  import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       take_i,
    output logic [2:0] gnt_o
);

    req_idx_e last_q, last_d;

    // No grants while reset is held so every ready reads 0.
    always_comb begin
        gnt_o = 3'b000;
        if (!rst) begin
            case (last_q)
                REQ_ALU: begin
                    if (req_i[1])      gnt_o = 3'b010;
                    else if (req_i[2]) gnt_o = 3'b100;
                    else if (req_i[0]) gnt_o = 3'b001;
                end
                REQ_LD: begin
                    if (req_i[2])      gnt_o = 3'b100;
                    else if (req_i[0]) gnt_o = 3'b001;
                    else if (req_i[1]) gnt_o = 3'b010;
                end
                default: begin
                    if (req_i[0])      gnt_o = 3'b001;
                    else if (req_i[1]) gnt_o = 3'b010;
                    else if (req_i[2]) gnt_o = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (take_i) begin
            if (gnt_o[0])      last_d = REQ_ALU;
            else if (gnt_o[1]) last_d = REQ_LD;
            else if (gnt_o[2]) last_d = REQ_MDU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= REQ_MDU;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU/LD/MDU results onto the register file's
// main and R0 write ports and tracks pending destinations for decode.
module regfile_wb_sched
  import regfile_pkg::*;
(
    input logic               clk,
    input logic               rst,
    regfile_wb_sched_if.slave bus
);

    logic [2:0]        req, gnt;
    logic              wr_q, wr_d, r15_q, r15_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, dr15_q, dr15_d;
    logic [NREG-1:0]   pending_q, pending_d;

    assign req = {bus.md_valid, bus.ld_valid, bus.alu_valid};

    rr_arb3 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .take_i (|(gnt & req)),
        .gnt_o  (gnt)
    );

    assign bus.alu_ready = gnt[REQ_ALU];
    assign bus.ld_ready  = gnt[REQ_LD];
    assign bus.md_ready  = gnt[REQ_MDU];

    always_comb begin
        wr_d   = 1'b0;
        r15_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        dr15_d = dr15_q;
        if (gnt[REQ_ALU]) begin
            wr_d   = 1'b1;
            addr_d = bus.alu_addr;
            data_d = bus.alu_data;
        end else if (gnt[REQ_LD]) begin
            wr_d   = 1'b1;
            addr_d = bus.ld_addr;
            data_d = bus.ld_data;
        end else if (gnt[REQ_MDU]) begin
            wr_d   = 1'b1;
            addr_d = bus.md_addr;
            data_d = bus.md_lo;
            // The main port owns R0, so md_hi is dropped when md_addr is R0.
            if (bus.md_addr != R0_IDX) begin
                r15_d  = 1'b1;
                dr15_d = bus.md_hi;
            end
        end
    end

    // Clears come from the write being presented now; a same-edge reservation wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_q)  pending_d[addr_q] = 1'b0;
        if (r15_q) pending_d[R0_IDX] = 1'b0;
        if (bus.rsv_valid) begin
            pending_d[bus.rsv_addr] = 1'b1;
            if (bus.rsv_r0) pending_d[R0_IDX] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            r15_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            dr15_q    <= '0;
            pending_q <= '0;
        end else begin
            wr_q      <= wr_d;
            r15_q     <= r15_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dr15_q    <= dr15_d;
            pending_q <= pending_d;
        end
    end

    // Masking with rst keeps an accepted-but-unissued write out of the file.
    assign bus.wr        = wr_q & ~rst;
    assign bus.wrR15     = r15_q & ~rst;
    assign bus.wrAddr    = addr_q;
    assign bus.wrData    = data_q;
    assign bus.wrDataR15 = dr15_q;
    assign bus.pending   = pending_q;
    assign bus.hazard    = pending_q[bus.chk_addr_a] | pending_q[bus.chk_addr_b];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus random traffic, checked
// each cycle against a behavioural model of arbitration, write-back and scoreboard.
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  localparam int W = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_sched_if bus ();

  regfile_wb_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  int                n_vec = 0;
  int                n_err = 0;
  int                m_last;
  int                m_g;
  logic [NREG-1:0]   m_pend;
  logic              m_wr, m_r15;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data, m_dr15;
  logic [W-1:0]      exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_wr   = 1'b0;
    m_r15  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_dr15 = '0;
    m_last = 2;
    m_g    = -1;
    exp_q.delete();
  endtask

  // Compare everything at the falling edge, and work out this cycle's grant.
  task automatic sample();
    logic [2:0] v;
    logic [W-1:0] e;
    int g;
    int idx;
    @(negedge clk);
    v = {bus.md_valid, bus.ld_valid, bus.alu_valid};
    g = -1;
    if (!rst) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (v[idx] && g < 0) g = idx;
      end
    end
    m_g = g;
    chk("ready", 32'({bus.md_ready, bus.ld_ready, bus.alu_ready}), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("hazard", 32'(bus.hazard), 32'(m_pend[bus.chk_addr_a] | m_pend[bus.chk_addr_b]));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("wr", 32'(bus.wr), 32'(m_wr & ~rst));
    chk("wrR15", 32'(bus.wrR15), 32'(m_r15 & ~rst));
    chk("wrAddr", 32'(bus.wrAddr), 32'(m_addr));
    chk("wrData", 32'(bus.wrData), 32'(m_data));
    chk("wrDataR15", 32'(bus.wrDataR15), 32'(m_dr15));
    if (m_wr && !rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wb_order", 32'({bus.wrAddr, bus.wrData}), 32'(e));
    end
  endtask

  // Apply this cycle's effects to the model, then cross the rising edge.
  task automatic advance();
    logic [NREG-1:0] np;
    if (rst) begin
      model_reset();
    end else begin
      np = m_pend;
      if (m_wr)  np[m_addr] = 1'b0;
      if (m_r15) np[0] = 1'b0;
      if (bus.rsv_valid) begin
        np[bus.rsv_addr] = 1'b1;
        if (bus.rsv_r0) np[0] = 1'b1;
      end
      m_pend = np;
      m_wr   = (m_g >= 0);
      m_r15  = 1'b0;
      if (m_g == 0) begin
        m_addr = bus.alu_addr;
        m_data = bus.alu_data;
      end else if (m_g == 1) begin
        m_addr = bus.ld_addr;
        m_data = bus.ld_data;
      end else if (m_g == 2) begin
        m_addr = bus.md_addr;
        m_data = bus.md_lo;
        if (bus.md_addr != 0) begin
          m_r15  = 1'b1;
          m_dr15 = bus.md_hi;
        end
      end
      if (m_g >= 0) begin
        exp_q.push_back({m_addr, m_data});
        m_last = m_g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // ---------------- drivers ----------------
  task automatic present(input int idx, input logic v);
    case (idx)
      0: begin
        bus.alu_valid = v;
        bus.alu_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        bus.alu_data  = DATA_W'($urandom);
      end
      1: begin
        bus.ld_valid = v;
        bus.ld_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        bus.ld_data  = DATA_W'($urandom);
      end
      default: begin
        bus.md_valid = v;
        bus.md_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        bus.md_lo    = DATA_W'($urandom);
        bus.md_hi    = DATA_W'($urandom);
      end
    endcase
  endtask

  task automatic drive_random();
    logic [2:0] v;
    v = {bus.md_valid, bus.ld_valid, bus.alu_valid};
    for (int i = 0; i < 3; i++)
      if (!v[i] || m_g == i) present(i, 1'($urandom_range(0, 1)));
    bus.rsv_valid  = ($urandom_range(0, 3) == 0);
    bus.rsv_addr   = ADDR_W'($urandom_range(0, NREG - 1));
    bus.rsv_r0     = 1'($urandom_range(0, 1));
    bus.chk_addr_a = ADDR_W'($urandom_range(0, NREG - 1));
    bus.chk_addr_b = ADDR_W'($urandom_range(0, NREG - 1));
    rst            = ($urandom_range(0, 49) == 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) present(i, 1'b0);
    bus.rsv_valid  = 1'b0;
    bus.rsv_addr   = '0;
    bus.rsv_r0     = 1'b0;
    bus.chk_addr_a = 4'd3;
    bus.chk_addr_b = 4'd9;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with every requester valid.
    for (int i = 0; i < 3; i++) present(i, 1'b1);
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("rst_ready", 32'({bus.md_ready, bus.ld_ready, bus.alu_ready}), 32'd0);
      chk("rst_wr", 32'({bus.wr, bus.wrR15}), 32'd0);
      chk("rst_pending", 32'(bus.pending), 32'd0);
      advance();
    end
    rst = 1'b0;

    // All three valid: grants rotate ALU, LD, MDU; then drain one each.
    for (int c = 0; c < 12; c++) begin
      sample();
      chk("rr_grant", 32'({bus.md_ready, bus.ld_ready, bus.alu_ready}), 32'd1 << (c % 3));
      if (c > 0) chk("rr_wr", 32'(bus.wr), 32'd1);
      advance();
      present(c % 3, (c < 9) ? 1'b1 : 1'b0);
    end
    step();

    // MDU split across both ports.
    bus.md_valid = 1'b1;
    bus.md_addr  = 4'd5;
    bus.md_lo    = 16'h1234;
    bus.md_hi    = 16'hABCD;
    step();
    bus.md_valid = 1'b0;
    sample();
    chk("mdu_split", 32'({bus.wr, bus.wrAddr, bus.wrData}), {11'd0, 1'b1, 4'd5, 16'h1234});
    chk("mdu_split_r15", 32'({bus.wrR15, bus.wrDataR15}), {15'd0, 1'b1, 16'hABCD});
    advance();

    // MDU to R0: main port only.
    bus.md_valid = 1'b1;
    bus.md_addr  = 4'd0;
    bus.md_lo    = 16'h0050;
    bus.md_hi    = 16'h9999;
    step();
    bus.md_valid = 1'b0;
    sample();
    chk("mdu_r0", 32'({bus.wr, bus.wrAddr, bus.wrData}), {11'd0, 1'b1, 4'd0, 16'h0050});
    chk("mdu_r0_r15", 32'(bus.wrR15), 32'd0);
    advance();

    // Reservation, in-flight hazard, clear.
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 4'd3;
    step();
    bus.rsv_valid = 1'b0;
    sample();
    chk("sb_hazard_set", 32'(bus.hazard), 32'd1);
    advance();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd3;
    bus.alu_data  = 16'h0303;
    step();
    bus.alu_valid = 1'b0;
    sample();
    chk("sb_hazard_inflight", 32'(bus.hazard), 32'd1);
    advance();
    sample();
    chk("sb_hazard_clear", 32'(bus.hazard), 32'd0);
    advance();

    // Reservation on the clearing edge survives.
    bus.rsv_valid = 1'b1;
    step();
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1;
    step();
    bus.alu_valid = 1'b0;
    bus.rsv_valid = 1'b1;
    step();
    bus.rsv_valid = 1'b0;
    sample();
    chk("sb_set_wins", 32'(bus.pending[3]), 32'd1);
    advance();
    bus.alu_valid = 1'b1;
    step();
    bus.alu_valid = 1'b0;
    step();

    // Reset right after a load is accepted drops the write.
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 4'd7;
    bus.ld_data   = 16'h7777;
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 4'd7;
    step();
    bus.ld_valid  = 1'b0;
    bus.rsv_valid = 1'b0;
    rst = 1'b1;
    sample();
    chk("midrst_wr", 32'(bus.wr), 32'd0);
    advance();
    rst = 1'b0;
    sample();
    chk("midrst_after", 32'({bus.wr, bus.wrR15, bus.wrAddr}), 32'd0);
    chk("midrst_pending", 32'(bus.pending), 32'd0);
    advance();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step();
      drive_random();
    end
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
